// File: rtl/hack_clock_pkg.sv
// Shared types, defaults and the half-period clamp for the Hack clock generator.
package hack_clock_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSED = 2'd1,
    STEP   = 2'd2
  } state_t;

  localparam int CNT_W_DEF        = 7;
  localparam int DEFAULT_HALF_DEF = 35;
  localparam int RISE_LEAD_DEF    = 2;

  // A phase must be long enough for the early-warning lead plus the toggle itself.
  function automatic int clamp_half(input int x, input int lead);
    return (x < lead + 2) ? lead + 2 : x;
  endfunction

endpackage

// File: rtl/hack_clock_gen.sv
// Runtime-programmable Hack CPU clock divider with run/pause/single-step control.
// Optional rising-edge cycle counter enabled by defining HACK_CLOCK_CYCLE_COUNT_EN.
module hack_clock_gen
  import hack_clock_pkg::*;
#(
  parameter int CNT_W         = CNT_W_DEF,
  parameter int DEFAULT_HALF  = DEFAULT_HALF_DEF,
  parameter int RISE_LEAD     = RISE_LEAD_DEF,
  parameter int START_RUNNING = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] half_period,
  input  logic             run_en,
  input  logic             step,
  output logic             hack_clk,
  output logic             strobe,
  output logic             going_to_rise,
  output logic             paused,
  output logic [31:0]      hack_cycles
);

  localparam logic [CNT_W-1:0] HP_RESET    = CNT_W'(clamp_half(DEFAULT_HALF, RISE_LEAD));
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
  localparam logic [CNT_W-1:0] LEAD_OFS    = CNT_W'(RISE_LEAD + 1);
  localparam state_t           STATE_RESET = (START_RUNNING != 0) ? RUN : PAUSED;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] hp_active_reg, hp_next;
  logic             hack_clk_reg, hack_clk_next;
  logic             strobe_reg, strobe_next;
  logic [CNT_W-1:0] hp_clamped;
  logic             is_term;

  assign hp_clamped = CNT_W'(clamp_half(int'(32'(half_period)), RISE_LEAD));
  assign is_term    = (cnt_reg == hp_active_reg - ONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= STATE_RESET;
      cnt_reg       <= '0;
      hp_active_reg <= HP_RESET;
      hack_clk_reg  <= 1'b0;
      strobe_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      hp_active_reg <= hp_next;
      hack_clk_reg  <= hack_clk_next;
      strobe_reg    <= strobe_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    hp_next       = hp_active_reg;
    hack_clk_next = hack_clk_reg;
    strobe_next   = 1'b0;
    case (state_reg)
      PAUSED: begin
        // run_en takes priority over step when both are presented.
        if (run_en) begin
          state_next = RUN;
          cnt_next   = '0;
          hp_next    = hp_clamped;
        end else if (step) begin
          state_next = STEP;
          cnt_next   = '0;
          hp_next    = hp_clamped;
        end
      end
      RUN, STEP: begin
        if (is_term) begin
          cnt_next      = '0;
          hack_clk_next = ~hack_clk_reg;
          strobe_next   = 1'b1;
          hp_next       = hp_clamped;
          // Pausing only at a falling toggle keeps hack_clk parked low.
          if (hack_clk_reg && (state_reg == STEP || !run_en)) begin
            state_next = PAUSED;
          end
        end else begin
          cnt_next = cnt_reg + ONE;
        end
      end
      default: begin
        state_next = PAUSED;
        cnt_next   = '0;
      end
    endcase
  end

  assign hack_clk      = hack_clk_reg;
  assign strobe        = strobe_reg;
  assign paused        = (state_reg == PAUSED);
  assign going_to_rise = (state_reg != PAUSED) && !hack_clk_reg &&
                         (cnt_reg == hp_active_reg - LEAD_OFS);

`ifdef HACK_CLOCK_CYCLE_COUNT_EN
  logic [31:0] cycles_reg;
  logic        rise_toggle;

  assign rise_toggle = (state_reg == RUN || state_reg == STEP) && is_term && !hack_clk_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycles_reg <= '0;
    end else if (rise_toggle) begin
      cycles_reg <= cycles_reg + 32'd1;
    end
  end

  assign hack_cycles = cycles_reg;
`else
  assign hack_cycles = '0;
`endif

endmodule

// File: tb/tb_hack_clock_gen.sv
// Randomized bench for hack_clock_gen against a countdown-style phase model.
module tb_hack_clock_gen;

  localparam int CNT_W        = 7;
  localparam int DEFAULT_HALF = 35;
  localparam int RISE_LEAD    = 2;
`ifdef HACK_CLOCK_CYCLE_COUNT_EN
  localparam bit CYC_EN = 1'b1;
`else
  localparam bit CYC_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [CNT_W-1:0] half_period;
  logic             run_en, step;
  logic             hack_clk, strobe, going_to_rise, paused;
  logic [31:0]      hack_cycles;
  logic             run_en_p, step_p;
  logic             hack_clk_p, strobe_p, going_to_rise_p, paused_p;
  logic [31:0]      hack_cycles_p;

  int checks = 0;
  int errors = 0;

  // Model: mode 0=run 1=paused 2=step; m_left = clk cycles left in current phase.
  int m_mode, m_left, m_clk, m_strobe;
  int unsigned m_cycles;

  always #5 clk = ~clk;

  hack_clock_gen #(.CNT_W(CNT_W), .DEFAULT_HALF(DEFAULT_HALF), .RISE_LEAD(RISE_LEAD),
                   .START_RUNNING(1)) u_dut (
    .clk(clk), .reset(reset), .half_period(half_period), .run_en(run_en), .step(step),
    .hack_clk(hack_clk), .strobe(strobe), .going_to_rise(going_to_rise),
    .paused(paused), .hack_cycles(hack_cycles)
  );

  hack_clock_gen #(.CNT_W(CNT_W), .DEFAULT_HALF(DEFAULT_HALF), .RISE_LEAD(RISE_LEAD),
                   .START_RUNNING(0)) u_dut_p (
    .clk(clk), .reset(reset), .half_period(half_period), .run_en(run_en_p), .step(step_p),
    .hack_clk(hack_clk_p), .strobe(strobe_p), .going_to_rise(going_to_rise_p),
    .paused(paused_p), .hack_cycles(hack_cycles_p)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int clampm(input int x);
    return (x < RISE_LEAD + 2) ? RISE_LEAD + 2 : x;
  endfunction

  task automatic model_reset();
    m_mode   = 0;
    m_clk    = 0;
    m_left   = clampm(DEFAULT_HALF);
    m_strobe = 0;
    m_cycles = 0;
  endtask

  task automatic model_step();
    if (m_mode == 1) begin
      m_strobe = 0;
      if (run_en) begin
        m_mode = 0; m_left = clampm(int'(half_period));
      end else if (step) begin
        m_mode = 2; m_left = clampm(int'(half_period));
      end
    end else if (m_left == 1) begin
      m_clk    = 1 - m_clk;
      m_strobe = 1;
      m_left   = clampm(int'(half_period));
      if (m_clk == 1) m_cycles++;
      else if (m_mode == 2 || !run_en) m_mode = 1;
    end else begin
      m_left--;
      m_strobe = 0;
    end
  endtask

  task automatic compare();
    check_val("hack_clk", 32'(hack_clk), 32'(m_clk));
    check_val("strobe", 32'(strobe), 32'(m_strobe));
    check_val("going_to_rise", 32'(going_to_rise),
              32'(m_mode != 1 && m_clk == 0 && m_left == RISE_LEAD + 1));
    check_val("paused", 32'(paused), 32'(m_mode == 1));
    check_val("hack_cycles", hack_cycles, CYC_EN ? m_cycles : 32'd0);
  endtask

  // Inputs are set just after a falling edge; the model advances at the rising edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic rand_inputs();
    if ($urandom_range(0, 39) == 0) half_period = 7'($urandom_range(0, 40));
    if ($urandom_range(0, 59) == 0) run_en = ~run_en;
    step = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    int p_rises, p_rise_at, p_fall_at, k;
    logic p_prev;
    reset = 1'b1; half_period = 7'd35; run_en = 1'b1; step = 1'b0;
    run_en_p = 1'b0; step_p = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_hack_clk", 32'(hack_clk), 32'd0);
    check_val("rst_paused_run", 32'(paused), 32'd0);
    check_val("rst_paused_p", 32'(paused_p), 32'd1);
    reset = 1'b0;
    model_reset();
    compare();

    // Defaults plus the START_RUNNING=0 instance: idle, then a single step.
    p_rises = 0; p_rise_at = -1; p_fall_at = -1; p_prev = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step_p = (i == 50);
      tick();
      if (i < 50) begin
        check_val("p_idle_paused", 32'(paused_p), 32'd1);
        check_val("p_idle_clk", 32'(hack_clk_p), 32'd0);
      end
      if (i == 51) check_val("p_stepping", 32'(paused_p), 32'd0);
      if (hack_clk_p && !p_prev) begin p_rises++; p_rise_at = i; end
      if (!hack_clk_p && p_prev) p_fall_at = i;
      p_prev = hack_clk_p;
    end
    step_p = 1'b0;
    check_val("p_rises", 32'(p_rises), 32'd1);
    check_val("p_rise_at", 32'(p_rise_at), 32'd85);
    check_val("p_fall_at", 32'(p_fall_at), 32'd120);
    check_val("p_paused_end", 32'(paused_p), 32'd1);
    check_val("p_cycles", hack_cycles_p, CYC_EN ? 32'd1 : 32'd0);
    $display("phase defaults: checks=%0d errors=%0d", checks, errors);

    // Mid-phase shrink then clamp of a tiny half-period.
    for (int i = 0; i < 200; i++) begin
      half_period = (i == 20) ? 7'd10 : half_period;
      if (i == 120) half_period = 7'd1;
      tick();
    end
    $display("phase retime: checks=%0d errors=%0d", checks, errors);

    // Pause, then present run_en and step together.
    run_en = 1'b0; half_period = 7'd5;
    k = 0;
    while (m_mode != 1 && k < 300) begin tick(); k++; end
    if (k >= 300) check_val("pause_timeout", 32'(paused), 32'd1);
    run_en = 1'b1; step = 1'b1;
    tick();
    step = 1'b0;
    repeat (40) tick();
    $display("phase run_and_step: checks=%0d errors=%0d", checks, errors);

    // Random traffic with one asynchronous reset landing in a high phase.
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      tick();
      if (i == 1500) begin
        step = 1'b0; run_en = 1'b1;
        k = 0;
        while (m_clk == 0 && k < 300) begin tick(); k++; end
        if (k >= 300) check_val("high_wait_timeout", 32'(hack_clk), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_val("async_rst_clk", 32'(hack_clk), 32'd0);
        check_val("async_rst_strobe", 32'(strobe), 32'd0);
        check_val("async_rst_cycles", hack_cycles, 32'd0);
        check_val("async_rst_paused_p", 32'(paused_p), 32'd1);
        model_reset();
        @(negedge clk);
        compare();
        reset = 1'b0;
        $display("reset applied mid-high-phase: checks=%0d errors=%0d", checks, errors);
      end
    end
    $display("phase random: checks=%0d errors=%0d", checks, errors);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
